// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, writable instruction memory and the
// IF/ID register feeding decode, with stall, redirect and HALT handling.
module fetch_stage #(
  parameter int              ADDR_W   = 5,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [7:0]      NOP      = 8'h00,
  parameter logic [7:0]      HALT     = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_addr,
  input  logic [7:0]        imem_wdata,
  output logic [7:0]        instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [15:0]       fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state, next_state;
  logic [7:0]        mem [2**ADDR_W];
  logic [7:0]        fetch_word;
  logic [ADDR_W-1:0] next_pc, next_instr_pc;
  logic [7:0]        next_instr;
  logic              next_valid;
  logic [15:0]       next_count;

  // NOTE: the memory is deliberately left out of reset so a program can be
  // loaded while reset is held low; resetting it would also block RAM inference.
  always_ff @(posedge clk) begin
    if (imem_we) mem[imem_addr] <= imem_wdata;
  end

  assign fetch_word = mem[pc];

  // NOTE: every signal gets its hold value first so no path through this
  // block leaves a variable unassigned and infers a latch.
  always_comb begin
    next_state    = state;
    next_pc       = pc;
    next_instr    = instr;
    next_instr_pc = instr_pc;
    next_valid    = instr_valid;
    next_count    = fetch_count;
    if (redirect) begin
      next_pc    = redirect_pc;
      next_instr = NOP;
      next_valid = 1'b0;
      next_state = RUN;
    end else if (!stall) begin
      case (state)
        RUN: begin
          next_instr    = fetch_word;
          next_instr_pc = pc;
          next_valid    = 1'b1;
          if (fetch_count != 16'hFFFF) next_count = fetch_count + 16'd1;
          if (fetch_word == HALT) next_state = HALTED;
          else                    next_pc    = pc + 1'b1;
        end
        HALTED: begin
          next_instr = NOP;
          next_valid = 1'b0;
        end
        default: next_state = RUN;
      endcase
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      instr       <= NOP;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= next_state;
      pc          <= next_pc;
      instr       <= next_instr;
      instr_pc    <= next_instr_pc;
      instr_valid <= next_valid;
      fetch_count <= next_count;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each driven cycle pushes the expected IF/ID
// and status values, which are popped and compared after the edge.
module tb_fetch_stage;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          reset, stall, redirect, imem_we;
  logic [AW-1:0] redirect_pc, imem_addr;
  logic [7:0]    imem_wdata;
  logic [7:0]    instr;
  logic [AW-1:0] instr_pc, pc;
  logic          instr_valid, halted;
  logic [15:0]   fetch_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]    instr;
    logic [AW-1:0] ipc;
    logic          valid;
    logic [AW-1:0] pc;
    logic          halted;
    logic [15:0]   cnt;
  } exp_t;

  exp_t sb[$];

  // reference state
  logic [7:0]    m_mem [32];
  logic [AW-1:0] m_pc, m_ipc;
  logic [7:0]    m_instr;
  logic          m_valid, m_halted;
  logic [15:0]   m_cnt;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .pc(pc), .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic rst, input logic st, input logic rd,
                       input logic [AW-1:0] rpc, input logic we = 1'b0,
                       input logic [AW-1:0] wa = '0, input logic [7:0] wd = 8'h00);
    logic [7:0] fw;
    exp_t e, got;
    reset = rst; stall = st; redirect = rd; redirect_pc = rpc;
    imem_we = we; imem_addr = wa; imem_wdata = wd;
    fw = m_mem[m_pc];
    if (!rst) begin
      m_pc = '0; m_instr = 8'h00; m_ipc = '0; m_valid = 1'b0; m_halted = 1'b0; m_cnt = '0;
    end else if (rd) begin
      m_pc = rpc; m_instr = 8'h00; m_valid = 1'b0; m_halted = 1'b0;
    end else if (!st) begin
      if (!m_halted) begin
        m_instr = fw; m_ipc = m_pc; m_valid = 1'b1;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (fw == 8'hFF) m_halted = 1'b1;
        else             m_pc = m_pc + 1'b1;
      end else begin
        m_instr = 8'h00; m_valid = 1'b0;
      end
    end
    if (we) m_mem[wa] = wd;
    e = '{instr: m_instr, ipc: m_ipc, valid: m_valid, pc: m_pc, halted: m_halted, cnt: m_cnt};
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      check("instr",       instr,       got.instr);
      check("instr_pc",    instr_pc,    got.ipc);
      check("instr_valid", instr_valid, got.valid);
      check("pc",          pc,          got.pc);
      check("halted",      halted,      got.halted);
      check("fetch_count", fetch_count, got.cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h40 + 8'(i);
    m_mem[0] = 8'h11; m_mem[1] = 8'h22; m_mem[2] = 8'h33; m_mem[3] = 8'hFF;
    m_pc = '0; m_ipc = '0; m_instr = '0; m_valid = 1'b0; m_halted = 1'b0; m_cnt = '0;

    // program load while reset is low
    for (int i = 0; i < 32; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, AW'(i), m_mem[i]);
    check("reset_instr", instr, 8'h00);
    check("reset_valid", instr_valid, 1'b0);

    // straight-line fetch into HALT
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("first_fetch", {instr, 3'b0, instr_pc, 7'b0, instr_valid}, {8'h11, 3'b0, 5'd0, 7'b0, 1'b1});
    check("first_pc", pc, 5'd1);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("halt_word", instr, 8'hFF);
    check("halt_rise", halted, 1'b1);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("halted_state", {instr, 7'b0, instr_valid, 3'b0, pc, fetch_count}, {8'h00, 7'b0, 1'b0, 3'b0, 5'd3, 16'd4});

    // restart at 0, stall two cycles at pc=2
    cycle(1'b1, 1'b0, 1'b1, 5'd0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("pre_stall_pc", pc, 5'd2);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("resume_mem2", instr, 8'h33);

    // redirect overrides stall
    cycle(1'b1, 1'b1, 1'b1, 5'd10);
    check("redir_bubble", instr_valid, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("redir_target", {instr, 3'b0, instr_pc}, {8'h4A, 3'b0, 5'd10});

    // halt again, then leave HALTED via redirect to 5
    cycle(1'b1, 1'b0, 1'b1, 5'd3);
    cycle(1'b1, 1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("halted_again", halted, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 5'd5);
    check("unhalt", halted, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("fetch_mem5", {instr, 3'b0, instr_pc}, {8'h45, 3'b0, 5'd5});

    // load mem[31] during a stall, redirect there and wrap
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 5'd31, 8'h42);
    cycle(1'b1, 1'b0, 1'b1, 5'd31);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("fetch_mem31", {instr, 3'b0, instr_pc, 3'b0, pc}, {8'h42, 3'b0, 5'd31, 3'b0, 5'd0});
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("wrap_mem0", instr, 8'h11);

    // same-cycle write and fetch at pc=1 sees old data; new data visible later
    cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 5'd1, 8'h5A);
    check("rw_old_data", instr, 8'h22);
    cycle(1'b1, 1'b0, 1'b1, 5'd1);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("rw_new_data", instr, 8'h5A);

    // reset mid-run at pc=7 with stall and redirect also high
    cycle(1'b1, 1'b0, 1'b1, 5'd6);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("pre_reset_pc", pc, 5'd7);
    cycle(1'b0, 1'b1, 1'b1, 5'd20);
    check("midreset", {instr, 7'b0, instr_valid, 3'b0, pc, fetch_count}, {8'h00, 7'b0, 1'b0, 3'b0, 5'd0, 16'd0});
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("retained_mem0", instr, 8'h11);
    cycle(1'b1, 1'b0, 1'b1, 5'd31);
    cycle(1'b1, 1'b0, 1'b0, '0);
    check("retained_mem31", instr, 8'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
